// File: rtl/mult_control_pkg.sv
// Shared constants and types for the shift-and-add multiplier sequencer.
// State codes are fixed so the unused code 2'b11 can be recovered explicitly.
package mult_control_pkg;

    localparam int unsigned SizeData = 32;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    // Decoded controller outputs, grouped so the decode is one assignment per state.
    typedef struct packed {
        logic a_sel;
        logic b_sel;
        logic prod_sel;
        logic add_sel;
        logic busy;
        logic done;
    } ctrl_t;

    localparam ctrl_t CtrlIdle = '{default: 1'b0};

    // One spare bit keeps the iteration counter from wrapping at size-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/mult_control_if.sv
// Requester/datapath-facing signal bundle of the multiplier sequencer.
// master is the requester + datapath side, slave is the sequencer itself.
interface mult_control_if;

    logic start;
    logic abort;
    logic b_lsb;
    logic a_sel;
    logic b_sel;
    logic prod_sel;
    logic add_sel;
    logic busy;
    logic done;

    modport master (
        output start,
        output abort,
        output b_lsb,
        input  a_sel,
        input  b_sel,
        input  prod_sel,
        input  add_sel,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        input  b_lsb,
        output a_sel,
        output b_sel,
        output prod_sel,
        output add_sel,
        output busy,
        output done
    );

endinterface

// File: rtl/mult_control_counter.sv
// Iteration up-counter: synchronous clear has priority over enable,
// tc_o flags the count value Last.
module mult_control_counter #(
    parameter int unsigned Width = 6,
    parameter int unsigned Last  = 31
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == Width'(Last));

endmodule

// File: rtl/mult_control.sv
// Sequencer for the 32-bit shift-and-add multiplier: runs Size accumulate cycles
// per start request and reports busy/done over a four-phase handshake.
module mult_control
    import mult_control_pkg::*;
#(
    parameter int unsigned Size = SizeData
) (
    input logic           clk_i,
    input logic           rst_ni,
    mult_control_if.slave bus_io
);

    localparam int unsigned CntW = cnt_width(Size);

    state_e state_q, state_d;
    logic   lsb_q;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_tc;
    ctrl_t  ctrl;

    // Counter sits at zero outside BUSY, so entering BUSY always starts from 0.
    mult_control_counter #(
        .Width (CntW),
        .Last  (Size - 1)
    ) u_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            lsb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lsb_q   <= bus_io.b_lsb;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b1;
        cnt_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_clr = 1'b0;
                cnt_en  = 1'b1;
                // Abort wins over the terminal count so done never follows an abort.
                if (bus_io.abort) begin
                    state_d = StIdle;
                end else if (cnt_tc) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!bus_io.start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore decode: depends on state_q and lsb_q only.
    always_comb begin
        ctrl = CtrlIdle;
        case (state_q)
            StBusy: begin
                ctrl.a_sel    = 1'b1;
                ctrl.b_sel    = 1'b1;
                ctrl.prod_sel = 1'b1;
                ctrl.add_sel  = lsb_q;
                ctrl.busy     = 1'b1;
            end
            StDone: begin
                ctrl.a_sel    = 1'b1;
                ctrl.b_sel    = 1'b1;
                ctrl.prod_sel = 1'b1;
                ctrl.done     = 1'b1;
            end
            default: begin
                ctrl = CtrlIdle;
            end
        endcase
    end

    assign bus_io.a_sel    = ctrl.a_sel;
    assign bus_io.b_sel    = ctrl.b_sel;
    assign bus_io.prod_sel = ctrl.prod_sel;
    assign bus_io.add_sel  = ctrl.add_sel;
    assign bus_io.busy     = ctrl.busy;
    assign bus_io.done     = ctrl.done;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control driving a behavioural shift-and-add datapath;
// expected products are queued at start and compared when done rises.
module tb_mult_control;

    logic        clk;
    logic        rst_n;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [63:0] a_reg;
    logic [31:0] b_reg;
    logic [63:0] prod;
    logic [63:0] exp_q[$];
    int          n_tests;
    int          n_fail;

    mult_control_if bus ();

    mult_control #(
        .Size (32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Datapath: A shifts left, B shifts right, product clears or accumulates A.
    always @(posedge clk) begin
        a_reg <= bus.a_sel ? (a_reg << 1) : {32'b0, a_in};
        b_reg <= bus.b_sel ? (b_reg >> 1) : b_in;
        if (!bus.prod_sel) begin
            prod <= '0;
        end else if (bus.add_sel) begin
            prod <= prod + a_reg;
        end
    end

    assign bus.b_lsb = bus.b_sel ? b_reg[1] : b_in[0];

    wire [5:0] outs = {bus.a_sel, bus.b_sel, bus.prod_sel, bus.add_sel, bus.busy, bus.done};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // abort_cyc / rst_cyc: BUSY cycle index to abort / reset in, -1 for none.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int abort_cyc,
                         input int rst_cyc, input int hold);
        logic [31:0] mask;
        logic [63:0] p;
        int          n;
        bit          cut;
        cut  = (abort_cyc >= 0) || (rst_cyc >= 0);
        mask = '0;
        n    = 0;
        a_in = a;
        b_in = b;
        bus.start = 1'b1;
        if (!cut) exp_q.push_back({32'b0, a} * {32'b0, b});
        tick();
        check_eq("busy_rise", {30'b0, bus.busy, bus.done}, 64'b10);
        while (bus.busy && n < 40) begin
            if (n < 32) mask[n] = bus.add_sel;
            if (n == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_async_outs", {58'b0, outs}, 64'd0);
                bus.start = 1'b0;
                break;
            end
            if (n == abort_cyc) bus.abort = 1'b1;
            tick();
            n++;
        end
        if (rst_cyc >= 0) begin
            tick();
            tick();
            check_eq("rst_held_outs", {58'b0, outs}, 64'd0);
            rst_n = 1'b1;
            tick();
            check_eq("rst_release_idle", {58'b0, outs}, 64'd0);
        end else if (abort_cyc >= 0) begin
            check_eq("abort_exit_cycle", 64'(n), 64'(abort_cyc + 1));
            check_eq("abort_no_done", {58'b0, outs}, 64'd0);
            bus.abort = 1'b0;
            bus.start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                check_eq("abort_idle", {58'b0, outs}, 64'd0);
            end
        end else begin
            check_eq("busy_cycles", 64'(n), 64'd32);
            check_eq("done_rise", {30'b0, bus.busy, bus.done}, 64'b01);
            check_eq("add_sel_pattern", {32'b0, mask}, {32'b0, b});
            if (exp_q.size() == 0) begin
                check_eq("sb_empty", 64'd0, 64'd1);
            end else begin
                check_eq("prod", prod, exp_q.pop_front());
            end
            p = prod;
            for (int i = 0; i < hold; i++) begin
                bus.abort = (i == 2);
                tick();
                check_eq("done_hold", {30'b0, bus.busy, bus.done}, 64'b01);
                check_eq("prod_hold", prod, p);
            end
            bus.abort = 1'b0;
            bus.start = 1'b0;
            tick();
            check_eq("done_fall", {58'b0, outs}, 64'd0);
            tick();
            check_eq("idle_after_done", {58'b0, outs}, 64'd0);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #1;
        check_eq("reset_outs", {58'b0, outs}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("idle_outs", {58'b0, outs}, 64'd0);
        check_eq("idle_prod_clear", prod, 64'd0);

        do_op(32'd3, 32'd5, -1, -1, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 0);
        do_op(32'h1234_5678, 32'd0, -1, -1, 0);
        do_op(32'd7, 32'h8000_0000, -1, -1, 0);
        do_op(32'hDEAD_BEEF, 32'h0F0F_1234, 10, -1, 0);
        do_op(32'd6, 32'd7, -1, -1, 0);
        do_op(32'hCAFE_0001, 32'hFFFF_FFFF, 31, -1, 0);
        do_op(32'hABCD_EF01, 32'h7654_3210, -1, 20, 0);
        do_op(32'd9, 32'd9, -1, -1, 0);
        do_op(32'd11, 32'd13, -1, -1, 5);
        do_op($urandom, $urandom, -1, -1, 1);

        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/mult_control.md
# mult_control

Sequencing FSM for the 32-bit shift-and-add multiplier datapath. It accepts a start request and drives the datapath mux selects (`a_sel`, `b_sel`, `prod_sel`, `add_sel`) for exactly `size` accumulate cycles. It consumes the datapath's `b_lsb` feedback and reports `busy` and `done` over a four-phase handshake. It sits between the bus-side requester and the datapath and is the only driver of the datapath select lines.

## Interface
Parameters:
- `size`, default `SIZE_DATA` (32): operand width; sets the iteration count.

Ports:
- `clk`  input  1  rising-edge clock, shared with the datapath.
- `reset`  input  1  asynchronous, active-low; `reset=0` forces IDLE immediately.
- `start`  input  1  request; level-sensitive, four-phase.
- `abort`  input  1  cancels an operation in BUSY.
- `b_lsb`  input  1  from datapath (LSB of the B-mux output).
- `a_sel`, `b_sel`  output  1 each  0 = load operand, 1 = shifted register value.
- `prod_sel`  output  1  0 = clear product, 1 = adder-select path.
- `add_sel`  output  1  0 = hold product, 1 = product + A.
- `busy`  output  1  high in BUSY.
- `done`  output  1  high in DONE; datapath `prod` is valid while high.

## Operation
- States: IDLE, BUSY, DONE. Encoding is 2-bit binary: IDLE=00, BUSY=01, DONE=10. The unused code 11 recovers to IDLE.
- IDLE
  - Outputs: `a_sel=0`, `b_sel=0`, `prod_sel=0`, `add_sel=0`, `busy=0`, `done=0`.
  - The datapath reloads A and B and clears the product every cycle.
  - `start=1` → BUSY; the iteration counter loads 0.
- BUSY
  - Outputs: `a_sel=1`, `b_sel=1`, `prod_sel=1`, `add_sel=lsb_q`, `busy=1`.
  - `lsb_q` is a flop sampling `b_lsb` every cycle in every state. It therefore equals the current B register bit 0.
  - The counter increments each cycle.
  - When the counter reaches `size-1`, the next state is DONE.
  - `abort=1` → IDLE at the next edge. `abort` has priority over the terminal count. `done` is never raised for an aborted operation.
- DONE
  - Outputs: `a_sel=1`, `b_sel=1`, `prod_sel=1`, `add_sel=0`, `done=1`, `busy=0`. The product register holds its value while A and B shift freely.
  - Stays in DONE while `start=1`. `start=0` → IDLE at the next edge.
  - `abort` is ignored in DONE.
- `start` is ignored in BUSY.
- A new operation requires `start` low for at least one cycle; DONE only exits on `start=0`.
- Counter width is `$clog2(size)+1` bits and the counter never wraps within an operation. Its value is undefined outside BUSY.

## Timing
- Reset values: state=IDLE, counter=0, `lsb_q=0`; all outputs 0.
- Let E0 be the edge that samples `start=1` in IDLE. At E0 the datapath holds A=`a`, B=`b`, prod=0.
- BUSY spans `size` cycles, from E0 to E0+`size`. The last accumulate lands at edge E0+`size`.
- `done` rises at E0+`size` and `prod` is final at that same edge. Latency from start to done is `size` cycles (32 by default).
- `done` falls one edge after `start` is sampled low.
- Async reset mid-BUSY: outputs go to 0 without waiting for a clock edge. The partial product is discarded, because IDLE selects clear.
- `abort` and terminal count on the same cycle → IDLE.
- All outputs are Moore (decoded from state and `lsb_q` only). There is no combinational path from `start` or `abort` to any output.

## Structure
- Shared include file (alongside `SIZE_DATA`): state encodings `ST_IDLE`, `ST_BUSY`, `ST_DONE`.
- One sub-module, `counterN`: parameterised up-counter with synchronous load-zero, enable and terminal-count output; async active-low clear.
- The FSM, the `lsb_q` flop and the output decode live in `mult_control`.

## Test plan
All scenarios run against the real datapath.
- 3 × 5, start held until done → `busy` for 32 cycles, `done` at E0+32, `prod`=15; `done` drops one edge after `start`=0.
- 0xFFFFFFFF × 0xFFFFFFFF → `prod`=0xFFFFFFFE00000001; `add_sel`=1 in all 32 BUSY cycles.
- 0x12345678 × 0 → `add_sel` never 1, `prod`=0 at done. Then 7 × 0x80000000 → `prod`=0x380000000, `add_sel` high only in BUSY cycle 31.
- `abort` in BUSY cycle 10 → IDLE next edge, `done` never asserted. A following start on 6 × 7 → 42.
- `reset`=0 in BUSY cycle 20 → outputs 0 immediately without a clock edge. After release, a start on 9 × 9 → 81 at E0+32.
- `start` held high through DONE for 5 cycles → `done` and `prod` stable for all 5; no restart until `start` has been low for one cycle.
